// File: rtl/key_pkg.sv
// Shared definitions for the key debounce interface consumer: bus layout and event encoding.
package key_pkg;

    localparam int NUM_KEYS  = 5;
    localparam int SHORT_OFS = 0;
    localparam int LONG_OFS  = 5;
    localparam int CONF_OFS  = 10;
    localparam int KEY_W     = 15;
    localparam int NUM_TYPES = 4;
    localparam int SLOT_W    = 3;
    localparam int TYPE_W    = 2;
    localparam int EVT_W     = SLOT_W + TYPE_W;

    // Code order doubles as the per-slot arbitration priority.
    typedef enum logic [TYPE_W-1:0] {
        EVT_PRESS   = 2'd0,
        EVT_LONG    = 2'd1,
        EVT_REPEAT  = 2'd2,
        EVT_RELEASE = 2'd3
    } evt_type_e;

    typedef struct packed {
        logic [SLOT_W-1:0] slot;
        evt_type_e         etype;
    } evt_word_t;

endpackage

// File: rtl/key_evt_fifo.sv
// Synchronous event FIFO with an occupancy count; push is ignored when full, pop when empty.
module key_evt_fifo #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 8,
    parameter int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [LVL_W-1:0] level,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (level == LVL_W'(DEPTH));
    assign empty    = (level == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem[rd_ptr];

    // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; entries are only read once the level says they were written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/key_event_decoder.sv
// Turns level-coded key flags into ordered PRESS/LONG/REPEAT/RELEASE events behind a valid/ready FIFO.
module key_event_decoder
    import key_pkg::*;
#(
    parameter int REPEAT_PERIOD = 200,
    parameter int FIFO_DEPTH    = 8,
    parameter int CNT_W         = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [KEY_W-1:0]                key_state,
    output logic                            evt_valid,
    input  logic                            evt_ready,
    output logic [SLOT_W-1:0]               evt_slot,
    output logic [TYPE_W-1:0]               evt_type,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
    output logic                            overflow
);

    localparam int               LVL_W  = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] PERIOD = CNT_W'(REPEAT_PERIOD);

    logic [KEY_W-1:0]                     key_state_q;
    logic [CNT_W-1:0]                     rpt_cnt [NUM_KEYS];
    logic [NUM_KEYS-1:0][NUM_TYPES-1:0]   pending;
    logic [NUM_KEYS-1:0][NUM_TYPES-1:0]   detected;
    logic [NUM_KEYS-1:0][NUM_TYPES-1:0]   grant;
    logic                                 push;
    logic                                 pop;
    logic                                 fifo_full;
    logic                                 fifo_empty;
    evt_word_t                            push_word;
    evt_word_t                            head_word;
    logic [NUM_KEYS-1:0]                  unused_conf;

    // Confirmed flags carry no events of their own.
    assign unused_conf = key_state_q[CONF_OFS +: NUM_KEYS];

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        detected = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            detected[i][EVT_PRESS]   =  key_state[SHORT_OFS+i] & ~key_state_q[SHORT_OFS+i];
            detected[i][EVT_LONG]    =  key_state[LONG_OFS+i]  & ~key_state_q[LONG_OFS+i];
            detected[i][EVT_REPEAT]  =  key_state[LONG_OFS+i]  & (rpt_cnt[i] == PERIOD);
            detected[i][EVT_RELEASE] = ~key_state[SHORT_OFS+i] &  key_state_q[SHORT_OFS+i];
        end
    end

    // Descending scan so the lowest slot, then highest-priority type, is the last write and wins.
    always_comb begin
        grant     = '0;
        push      = 1'b0;
        push_word = '0;
        if (!fifo_full) begin
            for (int s = NUM_KEYS - 1; s >= 0; s--) begin
                for (int t = NUM_TYPES - 1; t >= 0; t--) begin
                    if (pending[s][t]) begin
                        grant          = '0;
                        grant[s][t]    = 1'b1;
                        push           = 1'b1;
                        push_word.slot  = SLOT_W'(s);
                        push_word.etype = evt_type_e'(TYPE_W'(t));
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_state_q <= '0;
            pending     <= '0;
            overflow    <= 1'b0;
            for (int i = 0; i < NUM_KEYS; i++) rpt_cnt[i] <= '0;
        end else begin
            key_state_q <= key_state;
            // A bit leaving for the FIFO this edge is free to be re-armed by a new detection.
            pending     <= (pending & ~grant) | detected;
            if (|(detected & pending & ~grant)) overflow <= 1'b1;
            for (int i = 0; i < NUM_KEYS; i++) begin
                if (!key_state[LONG_OFS+i])   rpt_cnt[i] <= '0;
                else if (rpt_cnt[i] == PERIOD) rpt_cnt[i] <= CNT_W'(1);
                else                           rpt_cnt[i] <= rpt_cnt[i] + CNT_W'(1);
            end
        end
    end

    assign pop = evt_valid & evt_ready;

    key_evt_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (FIFO_DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_word),
        .pop       (pop),
        .pop_data  (head_word),
        .level     (fifo_level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign evt_valid = ~fifo_empty;
    assign evt_slot  = evt_valid ? head_word.slot : '0;
    assign evt_type  = evt_valid ? head_word.etype : EVT_PRESS;

endmodule
